// File: rtl/gate_driver_fault_monitor.sv
// Filters the gate driver's nFAULT/nOCTW pins and sequences automatic recovery
// through gate_driver_reset, ending in a supervisor-cleared lockout on persistent faults.
module gate_driver_fault_monitor #(
  parameter int clk_freq_hz    = 54_000_000,
  parameter int filter_us      = 2,
  parameter int retry_delay_us = 100,
  parameter int settle_us      = 10,
  parameter int max_retries    = 3
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       n_fault,
  input  logic       n_octw,
  input  logic       driver_enable,
  input  logic       reset_done,
  input  logic       clear_lockout,
  output logic       reset_start,
  output logic       slow_reset,
  output logic       fault,
  output logic       fault_lockout,
  output logic       octw_warning,
  output logic [7:0] fault_count
);

  localparam int ticks_per_us = clk_freq_hz / 1_000_000;
  localparam int filter_ticks = ticks_per_us * filter_us;
  localparam int retry_ticks  = ticks_per_us * retry_delay_us;
  localparam int settle_ticks = ticks_per_us * settle_us;
  localparam int max_ticks    = (retry_ticks > settle_ticks) ?
                                ((retry_ticks > filter_ticks) ? retry_ticks : filter_ticks) :
                                ((settle_ticks > filter_ticks) ? settle_ticks : filter_ticks);
  localparam int filt_w       = $clog2(filter_ticks) + 1;
  localparam int tmr_w        = $clog2(max_ticks) + 1;

  localparam logic [filt_w-1:0] filt_last   = filt_w'(filter_ticks - 1);
  localparam logic [tmr_w-1:0]  retry_last  = tmr_w'(retry_ticks - 1);
  localparam logic [tmr_w-1:0]  settle_last = tmr_w'(settle_ticks - 1);
  localparam logic [3:0]        retry_limit = 4'(max_retries);

  typedef enum logic [2:0] {IDLE, WAIT_RETRY, RESETTING, SETTLE, LOCKOUT} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic              fault_sync_p0, fault_sync_p1, octw_sync_p0, octw_sync_p1;
  logic              fault_filt, octw_filt;
  logic [filt_w-1:0] fault_fcnt, octw_fcnt;
  state_t            state;
  logic [tmr_w-1:0]  timer;
  logic [3:0]        retry_cnt;
  logic              reset_done_q;
  logic              done_rise;

  // Stage p0/p1: two-flop synchronizers, idle level is the released (high) pin
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      fault_sync_p0 <= 1'b1;
      fault_sync_p1 <= 1'b1;
      octw_sync_p0  <= 1'b1;
      octw_sync_p1  <= 1'b1;
    end else begin
      fault_sync_p0 <= n_fault;
      fault_sync_p1 <= fault_sync_p0;
      octw_sync_p0  <= n_octw;
      octw_sync_p1  <= octw_sync_p0;
    end
  end

  // Filter stage: state flips only after filter_ticks consecutive disagreeing samples
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      fault_filt <= 1'b0;
      fault_fcnt <= '0;
      octw_filt  <= 1'b0;
      octw_fcnt  <= '0;
    end else begin
      if (!fault_sync_p1 != fault_filt) begin
        if (fault_fcnt == filt_last) begin
          fault_filt <= ~fault_filt;
          fault_fcnt <= '0;
        end else begin
          fault_fcnt <= fault_fcnt + filt_w'(1);
        end
      end else begin
        fault_fcnt <= '0;
      end
      if (!octw_sync_p1 != octw_filt) begin
        if (octw_fcnt == filt_last) begin
          octw_filt <= ~octw_filt;
          octw_fcnt <= '0;
        end else begin
          octw_fcnt <= octw_fcnt + filt_w'(1);
        end
      end else begin
        octw_fcnt <= '0;
      end
    end
  end

  assign octw_warning = octw_filt;
  assign done_rise    = reset_done & ~reset_done_q;

  // Recovery FSM stage
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      retry_cnt     <= '0;
      reset_done_q  <= 1'b0;
      reset_start   <= 1'b0;
      slow_reset    <= 1'b0;
      fault         <= 1'b0;
      fault_lockout <= 1'b0;
      fault_count   <= '0;
    end else begin
      reset_done_q <= reset_done;
      reset_start  <= 1'b0;
      slow_reset   <= 1'b0;
      case (state)
        IDLE: begin
          // nFAULT is untrusted while the driver is disabled
          if (driver_enable && fault_filt) begin
            state       <= WAIT_RETRY;
            fault       <= 1'b1;
            retry_cnt   <= 4'd1;
            fault_count <= sat_inc(fault_count);
            timer       <= '0;
          end
        end
        WAIT_RETRY: begin
          if (!driver_enable) begin
            state     <= IDLE;
            fault     <= 1'b0;
            retry_cnt <= '0;
          end else if (timer == retry_last) begin
            reset_start <= 1'b1;
            slow_reset  <= (retry_cnt > 4'd1);
            state       <= RESETTING;
          end else begin
            timer <= timer + tmr_w'(1);
          end
        end
        RESETTING: begin
          if (done_rise) begin
            state <= SETTLE;
            timer <= '0;
          end
        end
        SETTLE: begin
          if (!driver_enable) begin
            state     <= IDLE;
            fault     <= 1'b0;
            retry_cnt <= '0;
          end else if (timer == settle_last) begin
            if (!fault_filt) begin
              state     <= IDLE;
              fault     <= 1'b0;
              retry_cnt <= '0;
            end else if (retry_cnt == retry_limit) begin
              state         <= LOCKOUT;
              fault_lockout <= 1'b1;
            end else begin
              retry_cnt <= retry_cnt + 4'd1;
              timer     <= '0;
              state     <= WAIT_RETRY;
            end
          end else begin
            timer <= timer + tmr_w'(1);
          end
        end
        LOCKOUT: begin
          if (clear_lockout) begin
            state         <= IDLE;
            fault         <= 1'b0;
            fault_lockout <= 1'b0;
            retry_cnt     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gate_driver_fault_monitor.md
# gate_driver_fault_monitor

Monitors the gate driver's open-drain nFAULT and nOCTW report pins, filters them, and runs automatic recovery by requesting enable-line resets from `gate_driver_reset`. Its `reset_start`/`slow_reset` outputs drive that block's inputs, and its `reset_done` input comes from that block's output. It sits between the driver pins and the motor-control supervisor. Persistent faults end in a lockout that only the supervisor can clear.

## Interface
- `clk_freq_hz`, 54_000_000, system clock frequency
- `filter_us`, 2, glitch-filter window on both pins
- `retry_delay_us`, 100, wait between fault detection and the reset request
- `settle_us`, 10, wait after `reset_done` before re-checking nFAULT
- `max_retries`, 3, reset attempts before lockout (1..15)

- `sys_clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `n_fault`  in  1  driver nFAULT pin, asynchronous, active-low
- `n_octw`  in  1  driver nOCTW pin, asynchronous, active-low
- `driver_enable`  in  1  supervisor enable (same signal that feeds `gate_driver_reset`)
- `reset_done`  in  1  from `gate_driver_reset`
- `clear_lockout`  in  1  one-cycle pulse; exits lockout
- `reset_start`  out  1  one-cycle reset request
- `slow_reset`  out  1  reset type, valid while `reset_start`=1
- `fault`  out  1  fault handling in progress or locked out
- `fault_lockout`  out  1  recovery abandoned
- `octw_warning`  out  1  filtered over-temp/over-current warning
- `fault_count`  out  8  saturating count of detected fault events

## Operation
- Derived constants: `ticks_per_us = clk_freq_hz/1_000_000`; `filter_ticks`, `retry_ticks` and `settle_ticks` are `ticks_per_us` × the corresponding `_us` parameter.
- Counter widths are `$clog2(max ticks)+1`.
- Synchronizer: each pin goes through a 2-FF synchronizer. The FFs reset to 1.
- Filter: there is one filter per pin. It holds a state (`fault_filt`, `octw_filt`; reset 0) and a counter.
  - The counter increments each cycle the synced pin level disagrees with the state.
  - The counter clears on agreement.
  - The state flips on the `filter_ticks`-th consecutive disagreeing sample, and the counter clears.
- `octw_warning` = `octw_filt`. It is informational only and has no effect on the FSM.
- FSM states:
  - IDLE: if `driver_enable` && `fault_filt`, go to WAIT_RETRY. Set `fault`=1, `retry_cnt`=1, increment `fault_count` (saturating at 255), clear the timer.
  - WAIT_RETRY: count to `retry_ticks`-1. Then pulse `reset_start` for one cycle with `slow_reset` = (`retry_cnt`>1) and go to RESETTING. The first attempt is therefore fast and later attempts are slow.
  - RESETTING: wait for a rising edge of `reset_done` (registered previous value 0, current value 1), then go to SETTLE with the timer cleared.
  - SETTLE: count to `settle_ticks`-1, then:
    - If `fault_filt`=0: go to IDLE with `fault`=0 and `retry_cnt`=0.
    - Else if `retry_cnt`==`max_retries`: go to LOCKOUT with `fault_lockout`=1.
    - Else: increment `retry_cnt` and go to WAIT_RETRY.
  - LOCKOUT: no reset requests are issued. `clear_lockout` moves to IDLE and clears `fault`, `fault_lockout` and `retry_cnt`. `fault_count` is kept.
- `driver_enable` low:
  - In IDLE, faults are ignored (nFAULT is not trusted while the driver is disabled).
  - In WAIT_RETRY or SETTLE, return to IDLE and clear `fault` and `retry_cnt`.
  - In RESETTING, it is ignored; the FSM still waits for `reset_done`.
  - In LOCKOUT, it is ignored.
- Simultaneous events:
  - `clear_lockout` outside LOCKOUT is ignored.
  - If `clear_lockout` arrives while `fault_filt` is still 1, the FSM goes to IDLE for one cycle and re-detects the fault on the next cycle.

## Timing
- Reset values: all outputs are 0, the FSM is in IDLE, and the filter states, timers and `retry_cnt` are 0.
- Reset mid-operation aborts immediately with no pending `reset_start`.
- Fault detection latency: a pin low from edge k gives `fault_filt`=1 after edge k+1+`filter_ticks`, and `fault`=1 one edge later.
- Release latency is symmetric.
- `reset_start` goes high exactly `retry_ticks` cycles after entry to WAIT_RETRY, and lasts one cycle.
- The `reset_done` rising edge is registered: SETTLE is entered on the cycle after the edge is seen.
- Worst-case time to lockout is roughly `max_retries` × (`retry_ticks` + reset duration + `settle_ticks`).

## Test plan
All scenarios use `clk_freq_hz`=10_000_000, `filter_us`=1, `retry_delay_us`=5, `settle_us`=2 and `max_retries`=3, giving `filter_ticks`=10, `retry_ticks`=50 and `settle_ticks`=20.

- **Glitch rejection:** `n_fault` low for 9 cycles → `fault` stays 0 and `fault_count` stays 0. Low for 10 cycles → `fault`=1 and `fault_count`=1.
- **Recoverable fault:** `n_fault` low for 40 cycles, `driver_enable`=1 → one `reset_start` pulse, 50 cycles after `fault` rises, with `slow_reset`=0. The model answers `reset_done` 0→1 after 50 cycles. After settle, `fault`=0.
- **Persistent fault:** `n_fault` held low → three `reset_start` pulses with `slow_reset` = 0, 1, 1, then `fault_lockout`=1 and no further pulses for 1000 cycles. `clear_lockout` with the pin released → `fault`=0, `fault_lockout`=0, `fault_count`=1.
- **Warning path:** `n_octw` low for 10 cycles → `octw_warning`=1 and no `reset_start`. Released for 10 cycles → `octw_warning`=0.
- **Disabled driver:** `driver_enable`=0 with `n_fault` low → `fault` stays 0. Drop `driver_enable` during WAIT_RETRY → IDLE, `fault`=0, no `reset_start`.
- **Reset mid-operation:** assert `reset` during RESETTING → all outputs 0 on the next edge. Asserting `reset_done` afterwards causes no action.
